// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 8:1 mux scan sequencer.
// next_enabled_ch() is only referenced when MUX_SCAN_MASK_EN is defined.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] ch;
    } ch_pick_t;

    // Lowest enabled channel index >= lo; lo may be NUM_CH meaning "past the end".
    function automatic ch_pick_t next_enabled_ch(input logic [NUM_CH-1:0] mask,
                                                 input logic [SEL_W:0]    lo);
        ch_pick_t r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                r.found = 1'b1;
                r.ch    = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable down-counter timing the per-channel settle interval.
module mux_scan_dwell_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Select sequencer for an 8:1 mux: settles each channel, samples Y onto a valid/ready
// stream and assembles an 8-bit frame. Optional channel masking via MUX_SCAN_MASK_EN.
module mux8_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic [NUM_CH-1:0] frame,
    output logic              done,
    output logic              busy
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [NUM_CH-1:0] chan_mask
`endif
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               out_data_q, out_data_d;
    logic               done_q, done_d;
    logic               empty_q, empty_d;
    logic [NUM_CH-1:0]  frame_q, frame_d;
    logic [NUM_CH-1:0]  frame_acc_q, frame_acc_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic               first_found, more_found;
    logic [SEL_W-1:0]   first_ch, more_ch;

    mux_scan_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (DWELL_LD),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // first_*: channel a scan begins on; more_*: channel following the current one.
`ifdef MUX_SCAN_MASK_EN
    ch_pick_t pick_first, pick_next;

    always_comb begin
        pick_first = next_enabled_ch(chan_mask, '0);
        pick_next  = next_enabled_ch(chan_mask, {1'b0, ch_q} + 4'd1);
    end

    assign first_found = pick_first.found;
    assign first_ch    = pick_first.ch;
    assign more_found  = pick_next.found;
    assign more_ch     = pick_next.ch;
`else
    assign first_found = 1'b1;
    assign first_ch    = '0;
    assign more_found  = (ch_q != SEL_W'(NUM_CH - 1));
    assign more_ch     = ch_q + 3'd1;
`endif

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        sel_d       = sel_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        empty_d     = empty_q;
        frame_d     = frame_q;
        frame_acc_d = frame_acc_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (start && !abort) begin
                    state_d     = SETTLE;
                    frame_acc_d = '0;
                    ch_d        = first_ch;
                    sel_d       = first_ch;
                    cnt_load    = first_found;
                    empty_d     = !first_found;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    sel_d       = '0;
                    ch_d        = '0;
                    empty_d     = 1'b0;
                end else if (empty_q) begin
                    // Nothing enabled: report an empty frame every cycle while it stays so.
                    done_d  = 1'b1;
                    frame_d = '0;
                    if (continuous) begin
                        ch_d     = first_ch;
                        sel_d    = first_ch;
                        cnt_load = first_found;
                        empty_d  = !first_found;
                    end else begin
                        state_d = IDLE;
                        empty_d = 1'b0;
                        ch_d    = '0;
                        sel_d   = '0;
                    end
                end else if (cnt_zero) begin
                    out_data_d        = mux_y;
                    out_ch_d          = ch_q;
                    frame_acc_d[ch_q] = mux_y;
                    out_valid_d       = 1'b1;
                    state_d           = PRESENT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            PRESENT: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    sel_d       = '0;
                    ch_d        = '0;
                    empty_d     = 1'b0;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (more_found) begin
                        ch_d     = more_ch;
                        sel_d    = more_ch;
                        cnt_load = 1'b1;
                        state_d  = SETTLE;
                    end else begin
                        frame_d     = frame_acc_q;
                        done_d      = 1'b1;
                        frame_acc_d = '0;
                        if (continuous) begin
                            state_d  = SETTLE;
                            ch_d     = first_ch;
                            sel_d    = first_ch;
                            cnt_load = first_found;
                            empty_d  = !first_found;
                        end else begin
                            state_d = IDLE;
                            ch_d    = '0;
                            sel_d   = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            sel_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b0;
            frame_q     <= '0;
            frame_acc_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            sel_q       <= sel_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            empty_q     <= empty_d;
            frame_q     <= frame_d;
            frame_acc_q <= frame_acc_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign frame     = frame_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
